// File: rtl/vdc_host_seq.sv
// vdc_host_seq: indirect VDC register access sequencer.
// Polls status, writes the register select, then accesses the data port.
module vdc_host_seq #(
    parameter int STB_CYCLES = 2,
    parameter int POLL_LIMIT = 1023,
    parameter bit SEL_CACHE  = 1'b1
) (
    input  logic       clk32,
    input  logic       reset_n,
    input  logic       req,
    input  logic       req_we,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       ack,
    output logic       err,
    output logic [7:0] rd_data,
    output logic       vdc_cs,
    output logic       vdc_rs,
    output logic       vdc_we,
    output logic [7:0] vdc_dout,
    input  logic [7:0] vdc_din
);

    localparam int CW = $clog2(STB_CYCLES + 1);
    localparam logic [CW-1:0] STB_END = CW'(STB_CYCLES);
    localparam logic [9:0] PLIM = 10'(POLL_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_SEL,
        S_DATA,
        S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] stb_cnt, stb_cnt_nx;
    logic [9:0]    poll_cnt, poll_cnt_nx;
    logic          lat_we, lat_we_nx;
    logic [7:0]    lat_reg, lat_reg_nx;
    logic [7:0]    lat_data, lat_data_nx;
    logic [7:0]    rd_q, rd_nx;
    logic          err_q, err_nx;
    logic          cache_vld, cache_vld_nx;
    logic [7:0]    cache_reg, cache_reg_nx;

    logic          in_acc;
    logic          strobe;
    logic          gap_end;
    logic          cache_hit;
    logic [9:0]    poll_inc;

    // An access state is split into STB_CYCLES strobe cycles and one gap.
    assign in_acc    = (state == S_POLL) || (state == S_SEL) ||
                       (state == S_DATA);
    assign strobe    = in_acc && (stb_cnt != STB_END);
    assign gap_end   = in_acc && (stb_cnt == STB_END);
    assign cache_hit = SEL_CACHE && cache_vld && (cache_reg == lat_reg);
    assign poll_inc  = (poll_cnt == PLIM) ? poll_cnt : poll_cnt + 10'd1;

    assign busy    = (state != S_IDLE);
    assign ack     = (state == S_DONE);
    assign err     = ack && err_q;
    assign rd_data = rd_q;
    assign vdc_cs  = strobe;
    assign vdc_rs  = strobe && (state == S_DATA);
    assign vdc_we  = strobe && ((state == S_SEL) ||
                                ((state == S_DATA) && lat_we));

    // Bus data: select value or write data, held for the whole strobe.
    always_comb begin
        vdc_dout = 8'h00;
        if (strobe && (state == S_SEL)) begin
            vdc_dout = lat_reg;
        end else if (strobe && (state == S_DATA) && lat_we) begin
            vdc_dout = lat_data;
        end
    end

    // State and datapath registers; reset drops the strobes at once.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            stb_cnt   <= '0;
            poll_cnt  <= '0;
            lat_we    <= 1'b0;
            lat_reg   <= 8'h00;
            lat_data  <= 8'h00;
            rd_q      <= 8'h00;
            err_q     <= 1'b0;
            cache_vld <= 1'b0;
            cache_reg <= 8'h00;
        end else begin
            state     <= state_nx;
            stb_cnt   <= stb_cnt_nx;
            poll_cnt  <= poll_cnt_nx;
            lat_we    <= lat_we_nx;
            lat_reg   <= lat_reg_nx;
            lat_data  <= lat_data_nx;
            rd_q      <= rd_nx;
            err_q     <= err_nx;
            cache_vld <= cache_vld_nx;
            cache_reg <= cache_reg_nx;
        end
    end

    // Next-state: strobe count, gap-time decisions and result capture.
    always_comb begin
        state_nx     = state;
        stb_cnt_nx   = stb_cnt;
        poll_cnt_nx  = poll_cnt;
        lat_we_nx    = lat_we;
        lat_reg_nx   = lat_reg;
        lat_data_nx  = lat_data;
        rd_nx        = rd_q;
        err_nx       = err_q;
        cache_vld_nx = cache_vld;
        cache_reg_nx = cache_reg;

        if (strobe) begin
            stb_cnt_nx = stb_cnt + 1'b1;
        end

        unique case (state)
            S_IDLE: begin
                if (req) begin
                    lat_we_nx   = req_we;
                    lat_reg_nx  = req_reg;
                    lat_data_nx = req_data;
                    poll_cnt_nx = '0;
                    err_nx      = 1'b0;
                    stb_cnt_nx  = '0;
                    state_nx    = S_POLL;
                end
            end
            S_POLL: begin
                if (gap_end) begin
                    stb_cnt_nx = '0;
                    if (vdc_din[7]) begin
                        state_nx = cache_hit ? S_DATA : S_SEL;
                    end else begin
                        poll_cnt_nx = poll_inc;
                        if (poll_inc == PLIM) begin
                            err_nx       = 1'b1;
                            cache_vld_nx = 1'b0;
                            state_nx     = S_DONE;
                        end
                    end
                end
            end
            S_SEL: begin
                if (gap_end) begin
                    stb_cnt_nx   = '0;
                    cache_vld_nx = 1'b1;
                    cache_reg_nx = lat_reg;
                    state_nx     = S_DATA;
                end
            end
            S_DATA: begin
                if (gap_end) begin
                    stb_cnt_nx = '0;
                    if (!lat_we) begin
                        rd_nx = vdc_din;
                    end
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vdc_host_seq.sv
// tb_vdc_host_seq: randomized accesses against a VDC bus model
// and a transaction-level reference for latency, results and cache.
module tb_vdc_host_seq;

    localparam int STB  = 2;
    localparam int PLIM = 8;

    logic       clk32 = 1'b0;
    logic       reset_n = 1'b0;
    logic       req = 1'b0;
    logic       req_we = 1'b0;
    logic [7:0] req_reg = 8'h00;
    logic [7:0] req_data = 8'h00;
    logic       busy, ack, err;
    logic [7:0] rd_data;
    logic       vdc_cs, vdc_rs, vdc_we;
    logic [7:0] vdc_dout;
    logic [7:0] vdc_din = 8'h00;

    int checks = 0;
    int errors = 0;

    // VDC side model
    logic [7:0] vmem [256];
    logic [7:0] vsel = 8'h00;
    int  npoll_rdy = 0;
    int  stat_k = 0;
    int  n_stat = 0, n_sel = 0, n_data = 0, n_ack = 0, stb_bad = 0;
    bit  in_stb = 1'b0;
    int  stb_len = 0;
    logic s_rs, s_we;
    logic [7:0] s_d;

    // reference state
    logic [7:0] ref_mem [256];
    bit         ref_cv = 1'b0;
    logic [7:0] ref_cr = 8'h00;
    logic [7:0] ref_rd = 8'h00;

    vdc_host_seq #(
        .STB_CYCLES(STB),
        .POLL_LIMIT(PLIM),
        .SEL_CACHE (1'b1)
    ) dut (
        .clk32   (clk32),
        .reset_n (reset_n),
        .req     (req),
        .req_we  (req_we),
        .req_reg (req_reg),
        .req_data(req_data),
        .busy    (busy),
        .ack     (ack),
        .err     (err),
        .rd_data (rd_data),
        .vdc_cs  (vdc_cs),
        .vdc_rs  (vdc_rs),
        .vdc_we  (vdc_we),
        .vdc_dout(vdc_dout),
        .vdc_din (vdc_din)
    );

    always #5 clk32 = ~clk32;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // bus monitor and VDC behaviour, sampled mid-cycle
    always @(negedge clk32) begin
        if (!reset_n) begin
            in_stb = 1'b0;
        end else begin
            if (ack) n_ack++;
            if (vdc_cs) begin
                if (!in_stb) begin
                    in_stb  = 1'b1;
                    stb_len = 1;
                    s_rs    = vdc_rs;
                    s_we    = vdc_we;
                    s_d     = vdc_dout;
                end else begin
                    stb_len++;
                    if (vdc_rs !== s_rs || vdc_we !== s_we ||
                        vdc_dout !== s_d)
                        stb_bad++;
                end
            end else if (in_stb) begin
                in_stb = 1'b0;
                chk("stb_len", stb_len, STB);
                if (!s_rs && !s_we) begin
                    n_stat++;
                    stat_k++;
                    vdc_din = {(stat_k > npoll_rdy), 7'($urandom)};
                end else if (!s_rs) begin
                    n_sel++;
                    vsel = s_d;
                end else begin
                    n_data++;
                    if (s_we) vmem[vsel] = s_d;
                    else vdc_din = vmem[vsel];
                end
            end
        end
    end

    task automatic do_access(input bit we, input logic [7:0] rg,
                             input logic [7:0] dt, input int npoll,
                             input bit poke, input int exp_lat_in);
        bit e, hit;
        int p, exp_lat, lat;
        logic [7:0] exp_rd;
        e   = (npoll >= PLIM);
        p   = e ? PLIM : npoll + 1;
        hit = !e && ref_cv && (ref_cr == rg);
        exp_lat = p * (STB + 1) + 1;
        if (!e) exp_lat += (hit ? 0 : STB + 1) + STB + 1;
        exp_rd = ref_rd;
        if (!e) begin
            if (we) ref_mem[rg] = dt;
            else exp_rd = ref_mem[rg];
            ref_cv = 1'b1;
            ref_cr = rg;
        end else begin
            ref_cv = 1'b0;
        end
        ref_rd = exp_rd;

        @(negedge clk32);
        npoll_rdy = npoll;
        stat_k = 0;
        n_stat = 0; n_sel = 0; n_data = 0; n_ack = 0; stb_bad = 0;
        req = 1'b1; req_we = we; req_reg = rg; req_data = dt;
        lat = 0;
        do begin
            @(negedge clk32);
            lat++;
            if (lat == 1) begin
                req = 1'b0;
                req_reg = 8'($urandom);
                req_data = 8'($urandom);
                chk("busy_rise", busy, 1);
            end
            if (poke && lat == 4) begin
                req = 1'b1;
                req_we = ~we;
            end
            if (poke && lat == 5) req = 1'b0;
        end while (!ack && lat < 2000);
        chk("ack_seen", ack, 1);
        chk("latency", lat, exp_lat);
        if (exp_lat_in > 0) chk("lat_spec", lat, exp_lat_in);
        chk("err", err, e);
        chk("rd_data", rd_data, exp_rd);
        chk("n_stat", n_stat, p);
        chk("n_sel", n_sel, (!e && !hit) ? 1 : 0);
        chk("n_data", n_data, e ? 0 : 1);
        chk("stb_stable", stb_bad, 0);
        req = 1'b1;
        @(negedge clk32);
        req = 1'b0;
        chk("ack_pulse", ack, 0);
        chk("done_req_ignored", busy, 0);
        chk("n_ack", n_ack, 1);
    endtask

    initial begin
        bit found;
        int pick;
        logic [7:0] rg;
        for (int i = 0; i < 256; i++) begin
            vmem[i] = 8'($urandom);
            ref_mem[i] = vmem[i];
        end
        vmem[1] = 8'h50;
        ref_mem[1] = 8'h50;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_rd", rd_data, 0);
        chk("rst_cs", {vdc_cs, vdc_rs, vdc_we}, 0);
        chk("rst_dout", vdc_dout, 0);
        @(negedge clk32);
        #2 reset_n = 1'b1;

        do_access(1'b1, 8'h1A, 8'hF0, 0, 1'b0, 10);
        chk("vmem_1a", vmem[8'h1A], 8'hF0);
        do_access(1'b0, 8'h01, 8'h00, 0, 1'b0, 10);
        chk("rd_r1", rd_data, 8'h50);
        do_access(1'b1, 8'h33, 8'h5A, 5, 1'b0, 25);
        do_access(1'b1, 8'h1F, 8'h11, 20, 1'b0, 25);
        do_access(1'b1, 8'h1F, 8'h22, 0, 1'b0, 10);
        do_access(1'b1, 8'h1F, 8'h33, 0, 1'b1, 7);
        chk("vmem_1f", vmem[8'h1F], 8'h33);

        // reset during a select strobe
        @(negedge clk32);
        npoll_rdy = 0; stat_k = 0; n_ack = 0;
        req = 1'b1; req_we = 1'b1; req_reg = 8'h22; req_data = 8'h77;
        found = 1'b0;
        for (int w = 0; w < 100 && !found; w++) begin
            @(negedge clk32);
            req = 1'b0;
            if (vdc_cs && !vdc_rs && vdc_we) found = 1'b1;
        end
        chk("sel_reached", found, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_cs", vdc_cs, 0);
        chk("arst_out", {busy, ack, err, vdc_rs, vdc_we}, 0);
        chk("arst_data", {rd_data, vdc_dout}, 0);
        repeat (3) @(negedge clk32);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clk32);
        chk("arst_no_ack", n_ack, 0);
        chk("arst_idle", busy, 0);
        ref_cv = 1'b0;
        ref_rd = 8'h00;
        do_access(1'b1, 8'h22, 8'h77, 1, 1'b0, 13);

        for (int t = 0; t < 40; t++) begin
            pick = $urandom_range(0, 3);
            rg = (pick == 0) ? 8'h1F : (pick == 1) ? 8'h05 :
                 (pick == 2) ? 8'h40 : 8'($urandom);
            do_access(1'($urandom), rg, 8'($urandom),
                      ($urandom_range(0, 3) == 0) ?
                      $urandom_range(0, 12) : $urandom_range(0, 2),
                      1'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
